// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//
// Posted-write FIFO sitting between the MEM-stage pipeline register and the
// data memory write port.  Committed stores (word / half / byte) are accepted
// in one cycle and drained to DM one per cycle, strictly in program order.
// A load whose word index matches any still-pending store raises ld_hazard.
//
// Ports
//   clk, reset         clock; synchronous active-high reset
//   st_valid/st_ready  store handshake; st_addr, st_data, st_width, st_pc
//                      describe the store (width 0=word, 1=half, 2=byte;
//                      width 3 is dropped)
//   ld_valid, ld_addr  load in MEM this cycle; ld_hazard = must stall
//   dm_busy            DM write port unavailable, inhibits draining
//   dm_we, dm_addr, dm_wd, dm_width, dm_pc
//                      DM write port, driven from the head entry
//   empty, count       occupancy (registered state only)
// ---------------------------------------------------------------------------
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 12
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     st_valid,
   input  logic [31:0]              st_addr,
   input  logic [31:0]              st_data,
   input  logic [1:0]               st_width,
   input  logic [31:0]              st_pc,
   output logic                     st_ready,
   input  logic                     ld_valid,
   input  logic [31:0]              ld_addr,
   output logic                     ld_hazard,
   input  logic                     dm_busy,
   output logic                     dm_we,
   output logic [31:0]              dm_addr,
   output logic [31:0]              dm_wd,
   output logic [1:0]               dm_width,
   output logic [31:0]              dm_pc,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;

   logic [31:0]   ent_addr_q  [DEPTH];
   logic [31:0]   ent_addr_d  [DEPTH];
   logic [31:0]   ent_data_q  [DEPTH];
   logic [31:0]   ent_data_d  [DEPTH];
   logic [1:0]    ent_width_q [DEPTH];
   logic [1:0]    ent_width_d [DEPTH];
   logic [31:0]   ent_pc_q    [DEPTH];
   logic [31:0]   ent_pc_d    [DEPTH];

   logic          push;
   logic          pop;
   logic          hit;
   logic [PW-1:0] offset;

   // Only the word-index bits of a load address take part in the compare.
   logic          ld_addr_unused;
   assign ld_addr_unused = ^{ld_addr[31:AW+2], ld_addr[1:0]};

   // -----------------------------------------------------------------------
   // Handshake, drain and outputs
   // -----------------------------------------------------------------------
   always_comb begin
      empty    = (count_q == '0);
      count    = count_q;
      // Readiness looks only at current occupancy: no bypass on a full
      // buffer even when the head drains in the same cycle.
      st_ready = (count_q != FULL);
      push     = st_valid & st_ready & (st_width != 2'd3);
      dm_we    = !empty & !dm_busy;
      pop      = dm_we;

      dm_addr  = '0;
      dm_wd    = '0;
      dm_width = '0;
      dm_pc    = '0;
      if (!empty) begin
         dm_addr  = ent_addr_q[rd_ptr_q];
         dm_wd    = ent_data_q[rd_ptr_q];
         dm_width = ent_width_q[rd_ptr_q];
         dm_pc    = ent_pc_q[rd_ptr_q];
      end
   end

   // -----------------------------------------------------------------------
   // Load hazard: entry i is occupied when its distance from the head
   // (modulo DEPTH) is below the occupancy.  The head still counts while
   // it is being written this cycle.
   // -----------------------------------------------------------------------
   always_comb begin
      hit    = 1'b0;
      offset = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         offset = PW'(i) - rd_ptr_q;
         if (({1'b0, offset} < count_q) &&
             (ent_addr_q[i][AW+1:2] == ld_addr[AW+1:2])) begin
            hit = 1'b1;
         end
      end
      ld_hazard = ld_valid & hit;
   end

   // -----------------------------------------------------------------------
   // Pointer / occupancy next state
   // -----------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // -----------------------------------------------------------------------
   // Entry storage next state
   // -----------------------------------------------------------------------
   always_comb begin
      ent_addr_d  = ent_addr_q;
      ent_data_d  = ent_data_q;
      ent_width_d = ent_width_q;
      ent_pc_d    = ent_pc_q;
      if (push) begin
         ent_addr_d[wr_ptr_q]  = st_addr;
         ent_data_d[wr_ptr_q]  = st_data;
         ent_width_d[wr_ptr_q] = st_width;
         ent_pc_d[wr_ptr_q]    = st_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry contents need no reset; occupancy alone decides validity.
   always_ff @(posedge clk) begin
      ent_addr_q  <= ent_addr_d;
      ent_data_q  <= ent_data_d;
      ent_width_q <= ent_width_d;
      ent_pc_q    <= ent_pc_d;
   end

endmodule

// File: tb/tb_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_buffer
//
// Self-checking bench for store_buffer.  A behavioural model holds the
// pending stores as a queue of records; accepted stores are appended at the
// clock edge, and a negedge monitor compares every DUT output against that
// queue, popping the head whenever a DM write is due.
// ---------------------------------------------------------------------------
module tb_store_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 12;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  width;
      logic [31:0] pc;
   } ent_t;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic                   st_valid = 1'b0;
   logic [31:0]            st_addr = '0;
   logic [31:0]            st_data = '0;
   logic [1:0]             st_width = '0;
   logic [31:0]            st_pc = '0;
   logic                   st_ready;
   logic                   ld_valid = 1'b0;
   logic [31:0]            ld_addr = '0;
   logic                   ld_hazard;
   logic                   dm_busy = 1'b0;
   logic                   dm_we;
   logic [31:0]            dm_addr;
   logic [31:0]            dm_wd;
   logic [1:0]             dm_width;
   logic [31:0]            dm_pc;
   logic                   empty;
   logic [$clog2(DEPTH):0] count;

   store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset(reset),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
      .st_width(st_width), .st_pc(st_pc), .st_ready(st_ready),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
      .dm_busy(dm_busy), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd),
      .dm_width(dm_width), .dm_pc(dm_pc), .empty(empty), .count(count)
   );

   always #5 clk = ~clk;

   ent_t exp_q[$];
   int   n_vec = 0;
   int   n_fail = 0;
   int   pre_pop_size = 0;
   int   drained = 0;
   bit   armed = 1'b0;
   bit   acc = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model update at the clock edge: reset discards everything; otherwise a
   // valid, non-width-3 store is taken when the pre-drain occupancy is below
   // DEPTH.  The drain itself is retired by the monitor half a cycle earlier.
   always @(posedge clk) begin
      acc = 1'b0;
      if (reset) begin
         exp_q.delete();
      end else if (st_valid && st_width != 2'd3 && pre_pop_size != DEPTH) begin
         exp_q.push_back('{addr: st_addr, data: st_data, width: st_width, pc: st_pc});
         acc = 1'b1;
      end
   end

   // Monitor: compare outputs, then retire the head if DM writes it.
   always @(negedge clk) begin
      if (armed) begin
         automatic int sz = exp_q.size();
         automatic bit hz = 1'b0;
         automatic bit we = (sz != 0) && !dm_busy;
         foreach (exp_q[k]) begin
            if (exp_q[k].addr[AW+1:2] == ld_addr[AW+1:2]) hz = 1'b1;
         end
         chk("count",     32'(count),     32'(sz));
         chk("empty",     32'(empty),     32'(sz == 0));
         chk("st_ready",  32'(st_ready),  32'(sz != DEPTH));
         chk("ld_hazard", 32'(ld_hazard), 32'(ld_valid && hz));
         chk("dm_we",     32'(dm_we),     32'(we));
         if (sz != 0) begin
            chk("dm_addr",  dm_addr,         exp_q[0].addr);
            chk("dm_wd",    dm_wd,           exp_q[0].data);
            chk("dm_width", 32'(dm_width),   32'(exp_q[0].width));
            chk("dm_pc",    dm_pc,           exp_q[0].pc);
         end else begin
            chk("dm_addr_idle", dm_addr, 32'h0);
            chk("dm_wd_idle",   dm_wd,   32'h0);
            chk("dm_pc_idle",   dm_pc,   32'h0);
         end
         pre_pop_size = sz;
         if (we) begin
            void'(exp_q.pop_front());
            drained++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] w, input logic [31:0] p);
      st_valid = 1'b1;
      st_addr  = a;
      st_data  = d;
      st_width = w;
      st_pc    = p;
   endtask

   // Hold the presented store until the model accepts it (bounded).
   task automatic wait_accept(input string nm);
      int t = 0;
      do begin
         tick();
         t++;
      end while (!acc && t < 40);
      if (!acc) begin
         n_vec++;
         n_fail++;
         $display("FAIL %s: store not accepted within %0d cycles", nm, t);
      end
      st_valid = 1'b0;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] w, input logic [31:0] p);
      present(a, d, w, p);
      wait_accept("send");
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset
      tick();
      armed = 1'b1;
      tick();
      reset = 1'b0;
      tick();

      // Single store
      send(32'h10, 32'hDEADBEEF, 2'd0, 32'h3000);
      repeat (3) tick();

      // Fill, full, held 5th store, then wrap
      dm_busy = 1'b1;
      for (int i = 0; i < 4; i++) send(32'(i * 4), 32'(i + 1), 2'd0, 32'h4000 + 32'(i * 4));
      present(32'h10, 32'd5, 2'd0, 32'h4010);
      repeat (3) tick();
      dm_busy = 1'b0;
      wait_accept("fifth");
      repeat (8) tick();

      // Simultaneous push and pop at count 2
      dm_busy = 1'b1;
      send(32'h40, 32'hA1, 2'd1, 32'h5000);
      send(32'h44, 32'hA2, 2'd2, 32'h5004);
      dm_busy = 1'b0;
      send(32'h48, 32'hA3, 2'd0, 32'h5008);
      repeat (6) tick();

      // Load hazard on a pending byte store
      dm_busy = 1'b1;
      send(32'h23, 32'h5A, 2'd2, 32'h6000);
      ld_valid = 1'b1;
      ld_addr  = 32'h20;
      tick();
      ld_addr  = 32'h24;
      tick();
      ld_addr  = 32'h20;
      tick();
      dm_busy = 1'b0;
      repeat (3) tick();
      ld_valid = 1'b0;

      // Reset with pending stores and a simultaneous store
      dm_busy = 1'b1;
      for (int i = 0; i < 3; i++) send(32'h80 + 32'(i * 4), 32'(i), 2'd0, 32'h7000);
      present(32'h90, 32'h99, 2'd0, 32'h7010);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      st_valid = 1'b0;
      dm_busy = 1'b0;
      repeat (4) tick();

      // Invalid width is dropped
      present(32'hA0, 32'h1234, 2'd3, 32'h8000);
      repeat (2) tick();
      st_valid = 1'b0;
      repeat (2) tick();

      // Randomised traffic
      for (int c = 0; c < 3000; c++) begin
         if (!(st_valid && st_width != 2'd3 && !acc && !reset)) begin
            automatic int r = int'($urandom_range(0, 99));
            if (r < 50) begin
               present(32'h100 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3))
                          + (32'($urandom_range(0, 1)) << 16),
                       $urandom(), 2'($urandom_range(0, 3)), $urandom());
               ld_valid = 1'b0;
            end else begin
               st_valid = 1'b0;
               ld_valid = (r < 85);
               ld_addr  = 32'h100 + (32'($urandom_range(0, 9)) << 2) + 32'($urandom_range(0, 3))
                          + (32'($urandom_range(0, 1)) << 14);
            end
         end else begin
            ld_valid = 1'b0;
         end
         dm_busy = ($urandom_range(0, 3) == 0);
         reset   = ($urandom_range(0, 299) == 0);
         tick();
      end

      st_valid = 1'b0;
      ld_valid = 1'b0;
      dm_busy  = 1'b0;
      reset    = 1'b0;
      repeat (10) tick();
      chk("drained_any", 32'(drained > 20), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write FIFO between the MEM-stage pipeline register and the data memory. It accepts committed stores (word, half-word, byte) from the pipeline in one cycle and drains them to the DM write port one per cycle, in program order. It raises a load-hazard stall when a load targets a word that still has a pending store, and exposes `empty` for instructions that require memory to be quiescent.

## Interface
Parameters:
- `DEPTH`, 4: number of entries. Must be a power of two, ≥ 2.
- `AW`, 12: word-index bits compared for hazards, taken from `addr[AW+1:2]`. 12 matches the 4096-word DM.

Ports:
- `clk` input 1: clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `st_valid` input 1: a store is presented this cycle.
- `st_addr` input 32: store byte address.
- `st_data` input 32: store data, already right-aligned (byte in [7:0], half in [15:0]).
- `st_width` input 2: 0 = word, 1 = half, 2 = byte. Value 3 is never enqueued.
- `st_pc` input 32: PC of the store, carried for the DM write log.
- `st_ready` output 1: buffer can accept a store this cycle.
- `ld_valid` input 1: a load is in MEM this cycle.
- `ld_addr` input 32: load byte address.
- `ld_hazard` output 1: load must stall this cycle.
- `dm_busy` input 1: DM write port unavailable; inhibits draining.
- `dm_we` output 1: DM write enable.
- `dm_addr` output 32: DM address.
- `dm_wd` output 32: DM write data.
- `dm_width` output 2: DM width code.
- `dm_pc` output 32: DM PC.
- `empty` output 1: no pending stores.
- `count` output $clog2(DEPTH)+1: current occupancy.

## Operation
- Storage is a circular FIFO.
  - Each entry holds {addr, data, width, pc}.
  - `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - `count` ranges 0..DEPTH.
- Enqueue: `push = st_valid & st_ready & (st_width != 3)`.
  - On push, the entry at `wr_ptr` is written and `wr_ptr` increments.
  - A store with width 3 is dropped silently.
- `st_ready = (count != DEPTH)`.
  - There is no same-cycle bypass when full, even if a drain occurs that cycle.
  - Upstream stalls while `st_ready` = 0 and holds its inputs stable.
- Drain: `dm_we = !empty & !dm_busy`.
  - `dm_addr`, `dm_wd`, `dm_width` and `dm_pc` come combinationally from the entry at `rd_ptr`.
  - When `empty`, these four outputs are 0.
  - `pop = dm_we`. On pop, `rd_ptr` increments at the same edge at which DM commits the write.
- Count update: push & !pop → +1; pop & !push → −1; both → unchanged.
- Hazard: `ld_hazard = ld_valid & OR over occupied entries of (entry.addr[AW+1:2] == ld_addr[AW+1:2])`.
  - The comparison is at word granularity, independent of width.
  - The head entry being drained this cycle still counts.
  - The store presented on `st_*` in the same cycle is not compared; the pipeline never issues a load and a store in the same MEM cycle.
- Ordering: stores reach DM strictly in acceptance order. Stores to the same word are never merged.

## Timing
- Reset:
  - Clears `wr_ptr`, `rd_ptr` and `count`. Entry contents are don't-care.
  - In the cycle after a reset edge: `count` = 0, `empty` = 1, `st_ready` = 1, `dm_we` = 0, `dm_*` = 0, `ld_hazard` = 0.
  - Reset takes precedence over a simultaneous push or pop. Pending stores are discarded, not drained.
  - Reset mid-drain: the write in that cycle still reaches DM, because DM samples `dm_we` at the same edge.
- Latency: a store accepted at edge N into an empty buffer, with `dm_busy` = 0, drives `dm_we` = 1 during cycle N+1. DM commits it at edge N+1.
- Throughput: one push and one pop per cycle. In steady state with no DM back-pressure, occupancy stays ≤ 1.
- `dm_busy` = 1 holds the head and all `dm_*` outputs stable and sets `dm_we` = 0.
- A load that hits a pending store stalls until the last matching entry has been popped. `ld_hazard` falls in the cycle after that pop edge, at which point the DM combinational read returns the updated word.
- `empty` and `count` are registered-state functions with no combinational path from `st_valid`.

## Test plan
- Single store:
  - Stimulus: reset; push word addr 0x10, data 0xDEADBEEF, pc 0x3000.
  - Required: `dm_we` = 1 in the next cycle with `dm_addr` = 0x10, `dm_wd` = 0xDEADBEEF, `dm_pc` = 0x3000; then `empty` = 1.
- Fill, full and wrap:
  - Stimulus: `dm_busy` = 1; push 5 stores to addrs 0x0, 0x4, 0x8, 0xC, 0x10, data 1..5.
  - Required: `st_ready` = 0 after the 4th push and the 5th push is held.
  - Stimulus: release `dm_busy`.
  - Required: drains 1..4 in order; the 5th is accepted in the first cycle with `st_ready` = 1 after the first drain; pointers wrap; final `count` = 0.
- Simultaneous push and pop:
  - Stimulus: at `count` = 2, push while draining.
  - Required: `count` stays 2; next `dm_addr` equals the second-oldest entry.
- Load hazard:
  - Stimulus: `dm_busy` = 1; pending byte store to 0x23.
  - Required: a load of 0x20 gives `ld_hazard` = 1; a load of 0x24 gives `ld_hazard` = 0.
  - Stimulus: release `dm_busy`.
  - Required: `ld_hazard` clears the cycle after the pop.
- Reset mid-operation:
  - Stimulus: 3 pending stores with `dm_busy` = 1; assert `reset` together with `st_valid`.
  - Required: next cycle `count` = 0, `dm_we` = 0; no further DM writes occur.
- Invalid width:
  - Stimulus: `st_width` = 3 with `st_valid` = 1.
  - Required: `count` unchanged; no DM write occurs.
